// File: rtl/jk_bank_rr_arbiter_if.sv
// Request/command/grant bundle shared by the JK bank requesters and its arbiter.
interface jk_bank_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] j_bus;
  logic [N_REQ*WIDTH-1:0] k_bus;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       q;
  logic                   busy;

  modport master (output req, j_bus, k_bus, input gnt, ack, q, busy);
  modport slave  (input req, j_bus, k_bus, output gnt, ack, q, busy);
endinterface

// File: rtl/jk_bank_rr_arbiter.sv
// Round-robin owner of a shared WIDTH-bit JK flip-flop bank; one op per 3 cycles.
//  state   | meaning
//  S_IDLE  | waiting for any req, pick winner from ptr upward
//  S_GRANT | gnt held, captured J/K applied to the bank at the next edge
//  S_ACK   | one-cycle ack pulse to the winner
module jk_bank_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  jk_bank_rr_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_GRANT = 2'b01;
  localparam logic [1:0] S_ACK   = 2'b10;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] win_nxt;
  logic             win_vld;
  logic [WIDTH-1:0] jr;
  logic [WIDTH-1:0] kr;
  logic [WIDTH-1:0] q_r;
  logic [N_REQ-1:0] gnt_r;
  logic [N_REQ-1:0] ack_r;
  logic             busy_r;

  // Scan from the farthest offset back to ptr so the nearest set request wins.
  always_comb begin
    win_nxt = '0;
    win_vld = 1'b0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      int idx;
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (bus.req[idx]) begin
        win_nxt = PTR_W'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      win    <= '0;
      jr     <= '0;
      kr     <= '0;
      q_r    <= '0;
      gnt_r  <= '0;
      ack_r  <= '0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            win    <= win_nxt;
            jr     <= bus.j_bus[int'(win_nxt)*WIDTH +: WIDTH];
            kr     <= bus.k_bus[int'(win_nxt)*WIDTH +: WIDTH];
            gnt_r  <= ONE << win_nxt;
            busy_r <= 1'b1;
            state  <= S_GRANT;
          end
        end
        S_GRANT: begin
          q_r   <= (jr & ~q_r) | (~kr & q_r);
          ack_r <= gnt_r;
          gnt_r <= '0;
          ptr   <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
          state <= S_ACK;
        end
        S_ACK: begin
          ack_r  <= '0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          gnt_r  <= '0;
          ack_r  <= '0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.ack  = ack_r;
  assign bus.q    = q_r;
  assign bus.busy = busy_r;
endmodule

// File: tb/tb_jk_bank_rr_arbiter.sv
// Directed bench for jk_bank_rr_arbiter: a 4-requester instance and a 3-requester one.
module tb_jk_bank_rr_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   fails;

  jk_bank_rr_arbiter_if #(.N_REQ(4), .WIDTH(8)) a_if ();
  jk_bank_rr_arbiter_if #(.N_REQ(3), .WIDTH(8)) b_if ();

  jk_bank_rr_arbiter #(.N_REQ(4), .WIDTH(8)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  jk_bank_rr_arbiter #(.N_REQ(3), .WIDTH(8)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] exp_rr [5];
  logic [3:0] got_rr [5];
  int         got_cyc [5];
  int         n_ack;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full handshake for one requester; req dropped on seeing ack.
  task automatic run_op(input string tag, input int r, input logic [7:0] jv,
                        input logic [7:0] kv, input logic [7:0] q_exp);
    a_if.req = 4'(1 << r);
    a_if.j_bus[r*8 +: 8] = jv;
    a_if.k_bus[r*8 +: 8] = kv;
    tick();
    chk({tag, "_gnt"}, 32'(a_if.gnt), 32'(1 << r));
    chk({tag, "_busy1"}, 32'(a_if.busy), 32'd1);
    chk({tag, "_ack0"}, 32'(a_if.ack), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(a_if.ack), 32'(1 << r));
    chk({tag, "_q"}, 32'(a_if.q), 32'(q_exp));
    chk({tag, "_gnt0"}, 32'(a_if.gnt), 32'd0);
    a_if.req = '0;
    tick();
    chk({tag, "_ackoff"}, 32'(a_if.ack), 32'd0);
    chk({tag, "_idle"}, 32'(a_if.busy), 32'd0);
  endtask

  initial begin
    total = 0; passed = 0; fails = 0;
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      got_rr[i] = '0;
      got_cyc[i] = -1;
    end
    rst = 1'b0;
    a_if.req = '0; a_if.j_bus = '0; a_if.k_bus = '0;
    b_if.req = '0; b_if.j_bus = '0; b_if.k_bus = '0;
    #2;
    chk("rst_q", 32'(a_if.q), 32'd0);
    chk("rst_gnt", 32'(a_if.gnt), 32'd0);
    chk("rst_ack", 32'(a_if.ack), 32'd0);
    chk("rst_busy", 32'(a_if.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // single requester, set all bits
    run_op("single", 0, 8'hFF, 8'h00, 8'hFF);
    // clear the low nibble to reach F0 (winner 0 again, ptr back to 1)
    run_op("clr", 0, 8'h00, 8'h0F, 8'hF0);
    // F0 with J=3C K=5A: hold/clear/set/toggle mix gives AC
    run_op("jk", 1, 8'h3C, 8'h5A, 8'hAC);

    // async reset while in GRANT with q=AC; ptr is 2 so requester 2 wins
    a_if.req = 4'b0100;
    a_if.j_bus = '0; a_if.k_bus = '0;
    tick();
    chk("ar_gnt", 32'(a_if.gnt), 32'b0100);
    chk("ar_qpre", 32'(a_if.q), 32'hAC);
    #2 rst = 1'b0;
    #1;
    chk("ar_q", 32'(a_if.q), 32'd0);
    chk("ar_gnt0", 32'(a_if.gnt), 32'd0);
    chk("ar_ack0", 32'(a_if.ack), 32'd0);
    chk("ar_busy0", 32'(a_if.busy), 32'd0);
    a_if.req = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("ar_noack1", 32'(a_if.ack), 32'd0);
    tick();
    chk("ar_noack2", 32'(a_if.ack), 32'd0);
    chk("ar_idle", 32'(a_if.busy), 32'd0);

    // round robin with all four held; each winner sets its own bit
    a_if.j_bus = {8'h08, 8'h04, 8'h02, 8'h01};
    a_if.k_bus = '0;
    a_if.req = 4'b1111;
    n_ack = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (a_if.ack != '0) begin
        if (n_ack < 5) begin
          got_rr[n_ack] = a_if.ack;
          got_cyc[n_ack] = c;
        end
        n_ack++;
      end
      if (c == 14) a_if.req = '0;
    end
    chk("rr_count", 32'(n_ack), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_ack%0d", i), 32'(got_rr[i]), 32'(exp_rr[i]));
      chk($sformatf("rr_cyc%0d", i), 32'(got_cyc[i]), 32'(1 + 3 * i));
    end
    chk("rr_q", 32'(a_if.q), 32'h0F);
    tick();
    tick();

    // early drop in GRANT plus J/K change after capture; ptr is 1, req2 wins
    a_if.req = 4'b0100;
    a_if.j_bus = '0; a_if.k_bus = '0;
    a_if.j_bus[16 +: 8] = 8'hFF;
    a_if.k_bus[16 +: 8] = 8'hFF;
    tick();
    chk("ed_gnt", 32'(a_if.gnt), 32'b0100);
    a_if.req = '0;
    a_if.j_bus = '0; a_if.k_bus = '0;
    tick();
    chk("ed_ack", 32'(a_if.ack), 32'b0100);
    chk("ed_q", 32'(a_if.q), 32'hF0);
    tick();
    chk("ed_ackoff", 32'(a_if.ack), 32'd0);
    // all requesting: the winner is exactly ptr, which must now be 3
    a_if.req = 4'b1111;
    tick();
    chk("ed_ptr3", 32'(a_if.gnt), 32'b1000);
    a_if.req = '0;
    tick();
    chk("ed_ptr3_ack", 32'(a_if.ack), 32'b1000);
    chk("ed_q_hold", 32'(a_if.q), 32'hF0);
    tick();

    // N_REQ=3: requester 2 wins, then 0 and 2 race after ptr wraps to 0
    b_if.req = 3'b100;
    tick();
    chk("b_gnt2", 32'(b_if.gnt), 32'b100);
    tick();
    chk("b_ack2", 32'(b_if.ack), 32'b100);
    b_if.req = 3'b101;
    tick();
    chk("b_idle", 32'(b_if.busy), 32'd0);
    tick();
    chk("b_gnt0", 32'(b_if.gnt), 32'b001);
    tick();
    chk("b_ack0", 32'(b_if.ack), 32'b001);
    tick();
    tick();
    chk("b_gnt2b", 32'(b_if.gnt), 32'b100);
    b_if.req = '0;
    tick();
    chk("b_ack2b", 32'(b_if.ack), 32'b100);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
